// File: rtl/input_conditioner.sv
// input_conditioner: two independent synchronise-and-debounce channels (I, S) with change strobes.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic inputClk,
  input  logic inputReset,
  input  logic rawI,
  input  logic rawS,
  output logic outputI,
  output logic outputS,
  output logic pulseI,
  output logic pulseS
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [1:0] raw_w, out_w, pulse_w;
  assign raw_w = {rawS, rawI};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic       sync1_q, sync2_q, out_q, out_d, pulse_q, pulse_d;
    logic [7:0] cnt_q, cnt_d;
    logic       differ, done;
    // a differing edge either advances the count or, on the last one, commits the new level
    always_comb begin
      differ  = sync2_q != out_q;
      done    = differ && cnt_q >= LAST;
      cnt_d   = (differ && !done) ? cnt_q + 8'd1 : 8'd0;
      out_d   = done ? sync2_q : out_q;
      pulse_d = done;
    end
    always_ff @(posedge inputClk) begin
      if (inputReset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= 8'd0;
        out_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        sync1_q <= raw_w[c];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        pulse_q <= pulse_d;
      end
    end
    assign out_w[c]   = out_q;
    assign pulse_w[c] = pulse_q;
  end
  assign outputI = out_w[0];
  assign outputS = out_w[1];
  assign pulseI  = pulse_w[0];
  assign pulseS  = pulse_w[1];
endmodule
